// File: rtl/demux_sched_pkg.sv
// -----------------------------------------------------------------------------
// demux_sched_pkg
// Shared constants, FSM state type, mode encodings and helpers for the
// demux_scheduler block (the sequencer that feeds the 1-to-4 2-bit demux).
// -----------------------------------------------------------------------------
package demux_sched_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_FIX = 1'b1;

   // One-hot decode of a channel number, matching the demux W/X/Y/Z outputs.
   function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] sel);
      onehot4 = 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/demux_scheduler_rr_pointer.sv
// -----------------------------------------------------------------------------
// rr_pointer
// Round-robin channel pointer with burst counter for demux_scheduler.
//
// Optional feature (macro DEMUX_SCHED_SKIP_EN): in round-robin mode, when the
// pointer channel is not ready at accept, the first ready channel in the order
// pointer+1, +2, +3 is chosen instead.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_advance    in   a round-robin word is accepted this cycle
//   i_out_ready  in   per-channel consumer ready (used by the skip logic)
//   i_mode       in   MODE_RR / MODE_FIX
//   o_chosen     out  channel to load on a round-robin accept
// -----------------------------------------------------------------------------
module rr_pointer
   import demux_sched_pkg::*;
#(
   parameter int BURST_LEN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_advance,
   input  logic [NUM_CH-1:0] i_out_ready,
   input  logic              i_mode,
   output logic [CH_W-1:0]   o_chosen
);

`ifdef DEMUX_SCHED_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic [CH_W-1:0] r_ptr;
   logic [3:0]      r_cnt;
   logic            r_mode_q;

   logic            w_found;
   logic [CH_W-1:0] w_skip_ch;
   logic [CH_W-1:0] w_idx;
   logic            w_skip;
   logic [3:0]      w_cnt_base;
   logic [3:0]      w_cnt_inc;

   // Search pointer+3 down to pointer+1 so the nearest ready channel wins.
   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      w_found   = 1'b0;
      w_skip_ch = r_ptr;
      w_idx     = r_ptr;
      for (int k = NUM_CH - 1; k >= 1; k--) begin
         w_idx = r_ptr + CH_W'(k);
         if (i_out_ready[w_idx]) begin
            w_found   = 1'b1;
            w_skip_ch = w_idx;
         end
      end
   end

   assign w_skip   = SKIP_EN && (i_mode == MODE_RR) && !i_out_ready[r_ptr] && w_found;
   assign o_chosen = w_skip ? w_skip_ch : r_ptr;

   // A MODE change restarts the burst; an accept in the same cycle counts
   // from the cleared value.
   assign w_cnt_base = (i_mode != r_mode_q) ? 4'd0 : r_cnt;
   assign w_cnt_inc  = w_cnt_base + 4'd1;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_mode_q <= MODE_RR;
      end else begin
         r_mode_q <= i_mode;
         if (i_advance && w_skip) begin
            // A skip starts a fresh burst on the chosen channel; with a burst
            // of one that burst is already complete.
            if (BURST_LEN == 1) begin
               r_ptr <= w_skip_ch + CH_W'(1);
               r_cnt <= '0;
            end else begin
               r_ptr <= w_skip_ch;
               r_cnt <= 4'd1;
            end
         end else if (i_advance) begin
            if (w_cnt_inc == 4'(BURST_LEN)) begin
               r_cnt <= '0;
               r_ptr <= r_ptr + CH_W'(1);
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end else begin
            r_cnt <= w_cnt_base;
         end
      end
   end

endmodule

// File: rtl/demux_scheduler.sv
// -----------------------------------------------------------------------------
// demux_scheduler
// Sequencer in front of the 1-to-4 2-bit demultiplexer. Accepts words through
// a valid/ready handshake, holds one word in an output register and presents
// it as demux A/SEL plus a one-hot per-channel valid strobe.
//
// Optional feature (macro DEMUX_SCHED_SKIP_EN): round-robin skips a non-ready
// channel at accept (implemented in rr_pointer).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_in_data    in   input word
//   i_in_valid   in   input word valid
//   o_in_ready   out  a word can be accepted this cycle
//   i_mode       in   0 = round-robin, 1 = fixed channel
//   i_fix_sel    in   destination channel in fixed mode
//   o_a          out  held word (demux A)
//   o_sel        out  held channel (demux SEL)
//   o_out_valid  out  one-hot valid, bit SEL high while a word is held
//   i_out_ready  in   per-channel consumer ready
//   o_busy       out  a word is held
// -----------------------------------------------------------------------------
module demux_scheduler
   import demux_sched_pkg::*;
#(
   parameter int DATA_W    = 2,
   parameter int BURST_LEN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic              i_mode,
   input  logic [CH_W-1:0]   i_fix_sel,
   output logic [DATA_W-1:0] o_a,
   output logic [CH_W-1:0]   o_sel,
   output logic [NUM_CH-1:0] o_out_valid,
   input  logic [NUM_CH-1:0] i_out_ready,
   output logic              o_busy
);

   state_e            r_state;
   state_e            w_next_state;
   logic [DATA_W-1:0] r_a;
   logic [CH_W-1:0]   r_sel;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_advance;
   logic [CH_W-1:0]   w_rr_chosen;
   logic [CH_W-1:0]   w_chosen;

   // In HOLD the slot frees exactly when the held word leaves, so a new word
   // can be taken in the same cycle (1 word/cycle throughput).
   assign o_in_ready = (r_state == IDLE) || i_out_ready[r_sel];
   assign w_in_fire  = i_in_valid && o_in_ready;
   assign w_out_fire = (r_state == HOLD) && i_out_ready[r_sel];
   assign w_advance  = w_in_fire && (i_mode == MODE_RR);
   assign w_chosen   = (i_mode == MODE_FIX) ? i_fix_sel : w_rr_chosen;

   rr_pointer #(
      .BURST_LEN (BURST_LEN)
   ) u_rr_pointer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_advance   (w_advance),
      .i_out_ready (i_out_ready),
      .i_mode      (i_mode),
      .o_chosen    (w_rr_chosen)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      o_busy       = 1'b0;
      o_out_valid  = '0;
      case (r_state)
         IDLE: begin
            if (w_in_fire) w_next_state = HOLD;
         end
         HOLD: begin
            o_busy      = 1'b1;
            o_out_valid = onehot4(r_sel);
            if (w_out_fire && !w_in_fire) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: the one-entry data register is reset as well, because A/SEL are
   // visible demux inputs and must read 0 after reset, not stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_sel <= '0;
      end else if (w_in_fire) begin
         r_a   <= i_in_data;
         r_sel <= w_chosen;
      end
   end

   assign o_a   = r_a;
   assign o_sel = r_sel;

endmodule

// File: tb/tb_demux_scheduler.sv
// -----------------------------------------------------------------------------
// tb_demux_scheduler
// Directed bench for demux_scheduler. Three instances share stimulus and
// differ only in BURST_LEN (1, 2, 3); each scenario observes one of them.
// -----------------------------------------------------------------------------
module tb_demux_scheduler;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_data;
   logic       in_valid;
   logic       mode;
   logic [1:0] fix_sel;
   logic [3:0] out_ready;

   logic       in_ready1, in_ready2, in_ready3;
   logic [1:0] a1, a2, a3;
   logic [1:0] sel1, sel2, sel3;
   logic [3:0] ov1, ov2, ov3;
   logic       busy1, busy2, busy3;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   demux_scheduler #(.DATA_W(2), .BURST_LEN(1)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .i_in_data (in_data), .i_in_valid (in_valid),
      .o_in_ready (in_ready1), .i_mode (mode), .i_fix_sel (fix_sel), .o_a (a1),
      .o_sel (sel1), .o_out_valid (ov1), .i_out_ready (out_ready), .o_busy (busy1));

   demux_scheduler #(.DATA_W(2), .BURST_LEN(2)) u_dut2 (
      .clk (clk), .rst_n (rst_n), .i_in_data (in_data), .i_in_valid (in_valid),
      .o_in_ready (in_ready2), .i_mode (mode), .i_fix_sel (fix_sel), .o_a (a2),
      .o_sel (sel2), .o_out_valid (ov2), .i_out_ready (out_ready), .o_busy (busy2));

   demux_scheduler #(.DATA_W(2), .BURST_LEN(3)) u_dut3 (
      .clk (clk), .rst_n (rst_n), .i_in_data (in_data), .i_in_valid (in_valid),
      .o_in_ready (in_ready3), .i_mode (mode), .i_fix_sel (fix_sel), .o_a (a3),
      .o_sel (sel3), .o_out_valid (ov3), .i_out_ready (out_ready), .o_busy (busy3));

   // Advance to just after the next rising edge; inputs change and outputs
   // are sampled here, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 2'd0;
      mode      = 1'b0;
      fix_sel   = 2'd0;
      out_ready = 4'hF;
      rst_n     = 1'b0;
      #3;
      rst_n     = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({a1, sel1, ov1, busy1, in_ready1} !== {2'd0, 2'd0, 4'd0, 1'b0, 1'b1}) begin
         $display("FAIL reset_state: a=%0d sel=%0d ov=%b busy=%b in_ready=%b, need 0 0 0000 0 1",
                  a1, sel1, ov1, busy1, in_ready1);
         n_fail++;
      end
      n_checks++;
      if ({busy2, busy3, ov2, ov3} !== 10'd0) begin
         $display("FAIL reset_others: busy2=%b busy3=%b ov2=%b ov3=%b, need all 0",
                  busy2, busy3, ov2, ov3);
         n_fail++;
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] dat  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      logic [1:0] esel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] eov  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = dat[i];
         tick();
         n_checks++;
         if (a1 !== dat[i] || sel1 !== esel[i] || ov1 !== eov[i]) begin
            $display("FAIL rr_word%0d: a=%0d sel=%0d ov=%b, need a=%0d sel=%0d ov=%b",
                     i, a1, sel1, ov1, dat[i], esel[i], eov[i]);
            n_fail++;
         end
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (busy1 !== 1'b0 || ov1 !== 4'h0 || a1 !== 2'd1) begin
         $display("FAIL rr_drain: busy=%b ov=%b a=%0d, need busy=0 ov=0000 a=1",
                  busy1, ov1, a1);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 1'b1;
      in_data  = 2'd0;
      tick();
      in_data   = 2'd2;
      out_ready = 4'b1101;
      tick();
      in_data = 2'd3;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (in_ready1 !== 1'b0 || a1 !== 2'd2 || sel1 !== 2'd1 || ov1 !== 4'h2) begin
            $display("FAIL stall_cyc%0d: in_ready=%b a=%0d sel=%0d ov=%b, need 0 2 1 0010",
                     c, in_ready1, a1, sel1, ov1);
            n_fail++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 4'hF;
      #1;
      n_checks++;
      if (in_ready1 !== 1'b1) begin
         $display("FAIL release_ready: in_ready=%b, need 1", in_ready1);
         n_fail++;
      end
      tick();
      n_checks++;
      if (busy1 !== 1'b0 || ov1 !== 4'h0 || a1 !== 2'd2 || sel1 !== 2'd1) begin
         $display("FAIL release_idle: busy=%b ov=%b a=%0d sel=%0d, need 0 0000 2 1",
                  busy1, ov1, a1, sel1);
         n_fail++;
      end
   endtask

   task automatic test_fixed_mode();
      logic [1:0] esel  [9] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
      logic       emode [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      in_valid = 1'b1;
      fix_sel  = 2'd3;
      for (int i = 0; i < 9; i++) begin
         mode    = emode[i];
         in_data = 2'(i);
         tick();
         n_checks++;
         if (sel2 !== esel[i] || a2 !== 2'(i)) begin
            $display("FAIL fixed_word%0d: sel=%0d a=%0d, need sel=%0d a=%0d",
                     i, sel2, a2, esel[i], 2'(i));
            n_fail++;
         end
      end
      in_valid = 1'b0;
      mode     = 1'b0;
      tick();
   endtask

   task automatic test_burst3();
      logic [1:0] esel [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = 2'(3 - (i % 4));
         tick();
         n_checks++;
         if (sel3 !== esel[i] || ov3 !== (4'b0001 << esel[i])) begin
            $display("FAIL burst3_word%0d: sel=%0d ov=%b, need sel=%0d",
                     i, sel3, ov3, esel[i]);
            n_fail++;
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      in_valid = 1'b1;
      in_data  = 2'd0;
      tick();
      in_data = 2'd1;
      tick();
      in_data   = 2'd3;
      out_ready = 4'b1011;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (a1 !== 2'd3 || sel1 !== 2'd2 || ov1 !== 4'h4) begin
         $display("FAIL hold_before_reset: a=%0d sel=%0d ov=%b, need 3 2 0100", a1, sel1, ov1);
         n_fail++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ov1 !== 4'h0 || a1 !== 2'd0 || sel1 !== 2'd0 || busy1 !== 1'b0) begin
         $display("FAIL async_reset: a=%0d sel=%0d ov=%b busy=%b, need 0 0 0000 0",
                  a1, sel1, ov1, busy1);
         n_fail++;
      end
      #2;
      rst_n     = 1'b1;
      out_ready = 4'hF;
      in_valid  = 1'b1;
      in_data   = 2'd1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (sel1 !== 2'd0 || a1 !== 2'd1 || ov1 !== 4'h1) begin
         $display("FAIL after_reset_word: sel=%0d a=%0d ov=%b, need 0 1 0001", sel1, a1, ov1);
         n_fail++;
      end
      tick();
   endtask

   task automatic test_skip();
      do_reset();
      in_valid = 1'b1;
      in_data  = 2'd0;
      tick();
      in_data   = 2'd2;
      out_ready = 4'b1101;
      tick();
      in_valid = 1'b0;
`ifdef DEMUX_SCHED_SKIP_EN
      n_checks++;
      if (sel1 !== 2'd2 || a1 !== 2'd2 || in_ready1 !== 1'b1) begin
         $display("FAIL skip_route: sel=%0d a=%0d in_ready=%b, need 2 2 1", sel1, a1, in_ready1);
         n_fail++;
      end
      tick();
      out_ready = 4'hF;
      in_valid  = 1'b1;
      in_data   = 2'd1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (sel1 !== 2'd3) begin
         $display("FAIL skip_pointer: sel=%0d, need 3", sel1);
         n_fail++;
      end
`else
      n_checks++;
      if (sel1 !== 2'd1 || a1 !== 2'd2 || in_ready1 !== 1'b0) begin
         $display("FAIL strict_route: sel=%0d a=%0d in_ready=%b, need 1 2 0", sel1, a1, in_ready1);
         n_fail++;
      end
      tick();
      tick();
      n_checks++;
      if (in_ready1 !== 1'b0 || busy1 !== 1'b1) begin
         $display("FAIL strict_wait: in_ready=%b busy=%b, need 0 1", in_ready1, busy1);
         n_fail++;
      end
      out_ready = 4'b1111;
      #1;
      n_checks++;
      if (in_ready1 !== 1'b1) begin
         $display("FAIL strict_release: in_ready=%b, need 1", in_ready1);
         n_fail++;
      end
`endif
      tick();
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 2'd0;
      mode      = 1'b0;
      fix_sel   = 2'd0;
      out_ready = 4'hF;
      #2;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_fixed_mode();
      test_burst3();
      test_reset_mid_hold();
      test_skip();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
